clock_alarm_scanner: RTL and testbench



---
 rtl/clock_alarm_pkg.sv | 23 ++
 rtl/clock_alarm_scanner_if.sv | 32 +++
 rtl/clock_alarm_scanner.sv | 141 ++++++++++++++
 tb/tb_clock_alarm_scanner.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_alarm_pkg.sv
// clock_alarm_scanner shared types: alarm table entry layout,
// scan FSM states and field positions.
package clock_alarm_pkg;

  localparam int ENTRY_EN_BIT = 31;
  localparam int ENTRY_OS_BIT = 30;
  localparam int TIME_W       = 24;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CHECK,
    CLEAR
  } scan_state_t;

  typedef struct packed {
    logic              en;
    logic              os;
    logic [5:0]        rsvd;
    logic [TIME_W-1:0] t;
  } alarm_entry_t;

endpackage

// File: rtl/clock_alarm_scanner_if.sv
// Avalon-MM bus between the alarm scanner (master) and the RAM (slave).
// address/chipselect/write/byteenable/writedata out, readdata back.
interface clock_alarm_scanner_if #(
  parameter int ADDR_W = 10
);

  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write,
    output avm_byteenable,
    output avm_writedata,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_chipselect,
    input  avm_write,
    input  avm_byteenable,
    input  avm_writedata,
    output avm_readdata
  );

endinterface

// File: rtl/clock_alarm_scanner.sv
// Scans the RAM alarm table once per tick and raises a sticky irq on a
// time match. Ports: clk, reset_n, tick, cur_time, irq_ack, avm (master),
// alarm_irq, alarm_index, busy, tick_overrun.
module clock_alarm_scanner
  import clock_alarm_pkg::*;
#(
  parameter int BASE_WORD   = 0,
  parameter int NUM_ENTRIES = 16,
  parameter int ADDR_W      = 10,
  localparam int IDX_W =
    (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   tick,
  input  logic [TIME_W-1:0]      cur_time,
  input  logic                   irq_ack,
  clock_alarm_scanner_if.master  avm,
  output logic                   alarm_irq,
  output logic [IDX_W-1:0]       alarm_index,
  output logic                   busy,
  output logic                   tick_overrun
);

  localparam logic [ADDR_W-1:0] BASE_A =
    ADDR_W'(BASE_WORD);
  localparam logic [IDX_W-1:0] LAST_I =
    IDX_W'(NUM_ENTRIES - 1);

  scan_state_t       state_q;
  scan_state_t       state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [TIME_W-1:0] t_lat;
  logic              pend;
  logic              hit_seen;
  logic [6:0]        keep_q;
  logic [ADDR_W-1:0] addr_q;
  alarm_entry_t      rd;
  logic              match;
  logic              last;
  logic              start;
  logic              adv;
  logic              cs;
  logic              wr;
  logic [3:0]        be;
  logic [31:0]       wd;

  assign rd    = alarm_entry_t'(avm.avm_readdata);
  assign last  = (idx_q == LAST_I);
  assign start = (state_q == IDLE) && (tick || pend);
  assign match = (state_q == CHECK) && rd.en &&
                 (rd.t == t_lat);
  // Stepping to the next entry: any transition into READ not from IDLE.
  assign adv   = (state_d == READ) && (state_q != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cs      = 1'b0;
    wr      = 1'b0;
    be      = 4'h0;
    wd      = '0;
    unique case (state_q)
      IDLE: begin
        if (tick || pend) state_d = READ;
      end
      READ: begin
        cs      = 1'b1;
        be      = 4'hF;
        state_d = CHECK;
      end
      CHECK: begin
        if (match && rd.os) state_d = CLEAR;
        else if (last)      state_d = IDLE;
        else                state_d = READ;
      end
      CLEAR: begin
        cs = 1'b1;
        wr = 1'b1;
        be = 4'b1000;
        wd[ENTRY_OS_BIT:TIME_W] = keep_q;
        wd[ENTRY_EN_BIT]        = 1'b0;
        state_d = last ? IDLE : READ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q        <= '0;
      t_lat        <= '0;
      pend         <= 1'b0;
      hit_seen     <= 1'b0;
      keep_q       <= '0;
      addr_q       <= '0;
      alarm_irq    <= 1'b0;
      alarm_index  <= '0;
      tick_overrun <= 1'b0;
    end else begin
      if (start) begin
        t_lat    <= cur_time;
        idx_q    <= '0;
        hit_seen <= 1'b0;
        addr_q   <= BASE_A;
      end else if (adv) begin
        idx_q  <= idx_q + 1'b1;
        addr_q <= BASE_A + ADDR_W'(idx_q) +
                  ADDR_W'(1);
      end
      if (start)     pend <= 1'b0;
      else if (tick) pend <= 1'b1;
      if (tick && pend) tick_overrun <= 1'b1;
      if (match) begin
        alarm_irq <= 1'b1;
        keep_q    <= {rd.os, rd.rsvd};
        if (!hit_seen) begin
          alarm_index <= idx_q;
          hit_seen    <= 1'b1;
        end
      end else if (irq_ack) begin
        alarm_irq <= 1'b0;
      end
    end
  end

  assign busy               = (state_q != IDLE);
  assign avm.avm_address    = addr_q;
  assign avm.avm_chipselect = cs;
  assign avm.avm_write      = wr;
  assign avm.avm_byteenable = be;
  assign avm.avm_writedata  = wd;

endmodule

// File: tb/tb_clock_alarm_scanner.sv
// Bench for clock_alarm_scanner: RAM model, scan-schedule reference
// model checked every cycle, and directed scenarios.
module tb_clock_alarm_scanner;

  localparam int NE   = 16;
  localparam int AW   = 10;
  localparam int BASE = 0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick = 1'b0;
  logic        irq_ack = 1'b0;
  logic [23:0] cur_time = '0;
  logic        alarm_irq;
  logic [3:0]  alarm_index;
  logic        busy;
  logic        tick_overrun;

  int n_chk = 0;
  int n_fail = 0;

  clock_alarm_scanner_if #(.ADDR_W(AW)) bus ();

  clock_alarm_scanner #(
    .BASE_WORD  (BASE),
    .NUM_ENTRIES(NE),
    .ADDR_W     (AW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick        (tick),
    .cur_time    (cur_time),
    .irq_ack     (irq_ack),
    .avm         (bus),
    .alarm_irq   (alarm_irq),
    .alarm_index (alarm_index),
    .busy        (busy),
    .tick_overrun(tick_overrun)
  );

  always #5 clk = ~clk;

  // RAM: one-cycle read latency, byte-masked writes, plus a CPU poke port.
  logic [31:0] mem [0:(1<<AW)-1];
  logic        cpu_we = 1'b0;
  logic [9:0]  cpu_addr = '0;
  logic [31:0] cpu_data = '0;
  int          wr_count = 0;
  logic [9:0]  wr_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;

  always @(posedge clk) begin
    if (cpu_we) mem[cpu_addr] <= cpu_data;
    if (bus.avm_chipselect) begin
      if (bus.avm_write) begin
        for (int b = 0; b < 4; b++)
          if (bus.avm_byteenable[b])
            mem[bus.avm_address][8*b +: 8] <=
              bus.avm_writedata[8*b +: 8];
        wr_count <= wr_count + 1;
        wr_addr  <= bus.avm_address;
        wr_be    <= bus.avm_byteenable;
        wr_data  <= bus.avm_writedata;
      end else begin
        bus.avm_readdata <= mem[bus.avm_address];
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: a scan is a list of bus cycles derived from the
  // table contents at scan start.
  // kind 0 = no access, 1 = read, 2 = write-back.
  typedef struct {
    int          kind;
    int          idx;
    bit          hit;
    bit          first;
    logic [31:0] wd;
  } op_t;

  op_t sched[$];
  bit  m_pend = 0;
  bit  m_ovr = 0;
  bit  m_irq = 0;
  int  m_idx = 0;

  function automatic void build(input logic [23:0] t);
    bit          got = 0;
    logic [31:0] ent;
    op_t         o;
    for (int e = 0; e < NE; e++) begin
      ent = mem[BASE + e];
      o = '{kind: 1, idx: e, hit: 0, first: 0, wd: '0};
      sched.push_back(o);
      o.kind  = 0;
      o.hit   = ent[31] && (ent[23:0] == t);
      o.first = o.hit && !got;
      sched.push_back(o);
      if (o.hit) got = 1;
      if (o.hit && ent[30]) begin
        o = '{kind: 2, idx: e, hit: 0, first: 0,
              wd: {1'b0, ent[30:24], 24'h0}};
        sched.push_back(o);
      end
    end
  endfunction

  always @(negedge clk) begin
    op_t o;
    bit  was_busy;
    if (!reset_n) begin
      sched.delete();
      m_pend = 0;
      m_ovr  = 0;
      m_irq  = 0;
      m_idx  = 0;
    end
    was_busy = (sched.size() > 0);
    o = was_busy ? sched[0] :
        '{kind: 0, idx: 0, hit: 0, first: 0, wd: '0};
    chk("busy", busy, was_busy);
    chk("chipselect", bus.avm_chipselect, o.kind != 0);
    chk("write", bus.avm_write, o.kind == 2);
    chk("byteenable", bus.avm_byteenable,
        o.kind == 1 ? 4'hF : o.kind == 2 ? 4'h8 : 4'h0);
    if (o.kind != 0)
      chk("address", bus.avm_address, BASE + o.idx);
    if (o.kind == 2)
      chk("writedata", bus.avm_writedata, o.wd);
    chk("alarm_irq", alarm_irq, m_irq);
    chk("alarm_index", alarm_index, m_idx);
    chk("tick_overrun", tick_overrun, m_ovr);
    if (reset_n) begin
      if (was_busy) void'(sched.pop_front());
      if (was_busy && o.hit) begin
        m_irq = 1;
        if (o.first) m_idx = o.idx;
      end else if (irq_ack) begin
        m_irq = 0;
      end
      if (tick && m_pend) m_ovr = 1;
      if (!was_busy) begin
        if (tick || m_pend) begin
          m_pend = 0;
          build(cur_time);
        end
      end else if (tick) begin
        m_pend = 1;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    cpu_addr = 10'(a);
    cpu_data = d;
    cpu_we   = 1'b1;
    cyc(1);
    cpu_we   = 1'b0;
  endtask

  task automatic do_tick(input logic [23:0] t);
    cur_time = t;
    tick     = 1'b1;
    cyc(1);
    tick     = 1'b0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    cyc(1);
    irq_ack = 1'b0;
  endtask

  // Counts busy cycles from now until IDLE; rise = first irq cycle.
  task automatic scan(output int n, output int rise);
    n = 0;
    rise = -1;
    while (busy && n < 200) begin
      if (alarm_irq && rise < 0) rise = n;
      n++;
      cyc(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int rise;
    int wc0;
    int k;

    for (int e = 0; e < NE; e++) poke(BASE + e, 32'h0);
    chk("rst_busy", busy, 0);
    chk("rst_irq", alarm_irq, 0);
    chk("rst_index", alarm_index, 0);
    chk("rst_overrun", tick_overrun, 0);
    chk("rst_cs", bus.avm_chipselect, 0);
    chk("rst_addr", bus.avm_address, 0);
    reset_n = 1'b1;
    cyc(2);

    // persistent hit on entry 3
    poke(3, 32'h8012_3000);
    wc0 = wr_count;
    do_tick(24'h12_30_00);
    scan(n, rise);
    chk("t1_busy_len", n, 32);
    chk("t1_irq_rise", rise, 8);
    chk("t1_index", alarm_index, 3);
    chk("t1_no_write", wr_count - wc0, 0);

    // one-shot on entry 5
    pulse_ack();
    chk("t2_ack", alarm_irq, 0);
    poke(3, 32'h0);
    poke(5, 32'hC007_1500);
    wc0 = wr_count;
    do_tick(24'h07_15_00);
    scan(n, rise);
    chk("t2_busy_len", n, 33);
    chk("t2_one_write", wr_count - wc0, 1);
    chk("t2_wr_addr", wr_addr, 5);
    chk("t2_wr_be", wr_be, 4'b1000);
    chk("t2_wr_byte", wr_data[31:24], 8'h40);
    chk("t2_readback", mem[5], 32'h4007_1500);
    chk("t2_index", alarm_index, 5);
    pulse_ack();
    do_tick(24'h07_15_00);
    scan(n, rise);
    chk("t2_rearm_len", n, 32);
    chk("t2_rearm_irq", alarm_irq, 0);

    // entries 2 and 9 both match
    poke(5, 32'h0);
    poke(2, 32'h8008_0000);
    poke(9, 32'h8008_0000);
    do_tick(24'h08_00_00);
    cyc(10);
    chk("t3_irq", alarm_irq, 1);
    chk("t3_index_early", alarm_index, 2);
    pulse_ack();
    chk("t3_acked", alarm_irq, 0);
    cyc(8);
    irq_ack = 1'b1;
    cyc(1);
    irq_ack = 1'b0;
    chk("t3_match_wins", alarm_irq, 1);
    scan(n, rise);
    chk("t3_index", alarm_index, 2);

    // disabled entry and off-by-one-second time
    poke(2, 32'h0);
    poke(9, 32'h0);
    pulse_ack();
    poke(0, 32'h0012_3000);
    wc0 = wr_count;
    do_tick(24'h12_30_00);
    scan(n, rise);
    chk("t4_dis_irq", alarm_irq, 0);
    chk("t4_dis_write", wr_count - wc0, 0);
    poke(0, 32'h8012_3000);
    do_tick(24'h12_30_01);
    scan(n, rise);
    chk("t4_time_irq", alarm_irq, 0);

    // tick mid-scan, then two ticks mid-scan
    do_tick(24'h0);
    cyc(10);
    do_tick(24'h0);
    scan(n, rise);
    chk("t5_rest_len", n, 21);
    cyc(1);
    chk("t5_rescan", busy, 1);
    chk("t5_no_ovr", tick_overrun, 0);
    scan(n, rise);
    chk("t5_second_len", n, 32);
    do_tick(24'h0);
    cyc(5);
    do_tick(24'h0);
    cyc(5);
    do_tick(24'h0);
    scan(n, rise);
    cyc(1);
    chk("t5_extra_scan", busy, 1);
    chk("t5_ovr", tick_overrun, 1);
    scan(n, rise);
    chk("t5_extra_len", n, 32);
    cyc(1);
    chk("t5_no_third", busy, 0);

    // reset during write-back
    poke(0, 32'h0);
    poke(4, 32'hC007_1500);
    do_tick(24'h07_15_00);
    k = 0;
    while (!bus.avm_write && k < 40) begin
      cyc(1);
      k++;
    end
    chk("t6_in_clear", bus.avm_write, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_cs_async", bus.avm_chipselect, 0);
    chk("t6_wr_async", bus.avm_write, 0);
    chk("t6_busy", busy, 0);
    chk("t6_irq", alarm_irq, 0);
    chk("t6_index", alarm_index, 0);
    chk("t6_ovr", tick_overrun, 0);
    chk("t6_be", bus.avm_byteenable, 0);
    chk("t6_wd", bus.avm_writedata, 0);
    chk("t6_addr", bus.avm_address, 0);
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    chk("t6_idle", busy, 0);
    chk("t6_abandoned", mem[4], 32'hC007_1500);
    do_tick(24'h07_15_00);
    chk("t6_rescan_cs", bus.avm_chipselect, 1);
    chk("t6_rescan_e0", bus.avm_address, BASE);
    scan(n, rise);
    chk("t6_len", n, 33);
    chk("t6_readback", mem[4], 32'h4007_1500);
    chk("t6_hit_index", alarm_index, 4);

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
